// File: rtl/nixie_pkg.sv
// Shared constants and state encoding for the IN-14 tube frame transmitter.
package nixie_pkg;

    localparam int FRAME_W   = 72;
    localparam int GAP_SLOTS = 1;
    localparam int IDX_W     = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_A = 2'd1,
        GAP     = 2'd2,
        SHIFT_B = 2'd3
    } tx_state_t;

endpackage

// File: rtl/nixie_frame_tx_if.sv
// Frame-pair handshake between the display controller (master) and the transmitter (slave).
interface nixie_frame_tx_if;
    import nixie_pkg::*;

    logic [FRAME_W-1:0] frame_a;
    logic [FRAME_W-1:0] frame_b;
    logic               frame_valid;
    logic               frame_ready;

    modport master (
        output frame_a,
        output frame_b,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_a,
        input  frame_b,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/nixie_pwm_gen.sv
// Free-running bank-select PWM; duty is shadowed at each counter wrap.
module nixie_pwm_gen #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty_a,
    output logic             pwm_next
);

    logic [PWM_W-1:0] count_reg;
    logic [PWM_W-1:0] shadow_reg;
    logic [PWM_W-1:0] count_next;
    logic [PWM_W-1:0] shadow_next;

    // pwm_next is the nominal level for the cycle after the coming edge, so a
    // parent that registers it stays aligned with count_reg.
    always_comb begin
        count_next  = count_reg + PWM_W'(1);
        shadow_next = (count_next == '0) ? duty_a : shadow_reg;
        pwm_next    = (count_next < shadow_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= '0;
            shadow_reg <= '0;
        end else begin
            count_reg  <= count_next;
            shadow_reg <= shadow_next;
        end
    end

endmodule

// File: rtl/nixie_frame_tx.sv
// Serialises a bank A / bank B frame pair MSB-first to the tube CPLD and drives bank PWM/blanking.
module nixie_frame_tx
    import nixie_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int PWM_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    nixie_frame_tx_if.slave   frame_if,
    input  logic [PWM_W-1:0]  duty_a,
    input  logic              blank,
    output logic              busy,
    output logic              tube_clk,
    output logic              tube_data,
    output logic              tube_sel,
    output logic              tube_pwm,
    output logic              tube_en
);

    localparam int               PH_W       = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_RISE    = PH_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(FRAME_W - 1);
    localparam logic [IDX_W-1:0] GAP_LAST   = IDX_W'(GAP_SLOTS - 1);

    tx_state_t          state_reg;
    logic [PH_W-1:0]    phase_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [FRAME_W-1:0] shift_a_reg;
    logic [FRAME_W-1:0] shift_b_reg;
    logic               frame_ready_reg;
    logic               busy_reg;
    logic               tube_clk_reg;
    logic               tube_data_reg;
    logic               tube_sel_reg;
    logic               tube_pwm_reg;
    logic               tube_en_reg;
    logic               pwm_next;
    logic               slot_end;
    logic               clk_rise;

    nixie_pwm_gen #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .duty_a   (duty_a),
        .pwm_next (pwm_next)
    );

    assign slot_end = (phase_reg == PH_LAST);
    assign clk_rise = (phase_reg == PH_RISE);

    // tube_pwm defaults to the nominal waveform; states that rewrite the
    // displayed register force the other bank onto the tubes instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            phase_reg       <= '0;
            idx_reg         <= '0;
            shift_a_reg     <= '0;
            shift_b_reg     <= '0;
            frame_ready_reg <= 1'b0;
            busy_reg        <= 1'b0;
            tube_clk_reg    <= 1'b0;
            tube_data_reg   <= 1'b0;
            tube_sel_reg    <= 1'b0;
            tube_pwm_reg    <= 1'b0;
            tube_en_reg     <= 1'b0;
        end else begin
            tube_en_reg  <= ~blank;
            tube_pwm_reg <= pwm_next;
            case (state_reg)
                IDLE: begin
                    frame_ready_reg <= 1'b1;
                    if (frame_if.frame_valid && frame_ready_reg) begin
                        state_reg       <= SHIFT_A;
                        frame_ready_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                        phase_reg       <= '0;
                        idx_reg         <= '0;
                        tube_sel_reg    <= 1'b1;
                        tube_data_reg   <= frame_if.frame_a[FRAME_W-1];
                        shift_a_reg     <= {frame_if.frame_a[FRAME_W-2:0], 1'b0};
                        shift_b_reg     <= frame_if.frame_b;
                        tube_pwm_reg    <= 1'b0;
                    end
                end
                SHIFT_A: begin
                    tube_pwm_reg <= 1'b0;
                    if (slot_end) begin
                        phase_reg    <= '0;
                        tube_clk_reg <= 1'b0;
                        if (idx_reg == FRAME_LAST) begin
                            state_reg     <= GAP;
                            idx_reg       <= '0;
                            tube_sel_reg  <= 1'b0;
                            tube_data_reg <= 1'b0;
                            tube_pwm_reg  <= pwm_next;
                        end else begin
                            idx_reg       <= idx_reg + IDX_W'(1);
                            tube_data_reg <= shift_a_reg[FRAME_W-1];
                            shift_a_reg   <= {shift_a_reg[FRAME_W-2:0], 1'b0};
                        end
                    end else begin
                        phase_reg <= phase_reg + PH_W'(1);
                        if (clk_rise) begin
                            tube_clk_reg <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    // No rising edge here: the CPLD gets a quiet slot to switch registers.
                    if (slot_end) begin
                        phase_reg <= '0;
                        if (idx_reg == GAP_LAST) begin
                            state_reg     <= SHIFT_B;
                            idx_reg       <= '0;
                            tube_data_reg <= shift_b_reg[FRAME_W-1];
                            shift_b_reg   <= {shift_b_reg[FRAME_W-2:0], 1'b0};
                            tube_pwm_reg  <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end else begin
                        phase_reg <= phase_reg + PH_W'(1);
                    end
                end
                SHIFT_B: begin
                    tube_pwm_reg <= 1'b1;
                    if (slot_end) begin
                        phase_reg    <= '0;
                        tube_clk_reg <= 1'b0;
                        if (idx_reg == FRAME_LAST) begin
                            state_reg     <= IDLE;
                            idx_reg       <= '0;
                            busy_reg      <= 1'b0;
                            tube_data_reg <= 1'b0;
                            tube_pwm_reg  <= pwm_next;
                        end else begin
                            idx_reg       <= idx_reg + IDX_W'(1);
                            tube_data_reg <= shift_b_reg[FRAME_W-1];
                            shift_b_reg   <= {shift_b_reg[FRAME_W-2:0], 1'b0};
                        end
                    end else begin
                        phase_reg <= phase_reg + PH_W'(1);
                        if (clk_rise) begin
                            tube_clk_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign frame_if.frame_ready = frame_ready_reg;
    assign busy                 = busy_reg;
    assign tube_clk             = tube_clk_reg;
    assign tube_data            = tube_data_reg;
    assign tube_sel             = tube_sel_reg;
    assign tube_pwm             = tube_pwm_reg;
    assign tube_en              = tube_en_reg;

endmodule

// File: tb/tb_nixie_frame_tx.sv
// Directed bench for nixie_frame_tx: CPLD shift model, PWM duty counts, handshake, reset abort, blanking.
module tb_nixie_frame_tx;

    localparam int CD     = 1;
    localparam int PW     = 8;
    localparam int PERIOD = 1 << PW;
    localparam int FRAME_CYC = (72 + 1 + 72) * 2 * CD;

    typedef struct {
        logic [71:0] fa;
        logic [71:0] fb;
        logic [7:0]  duty;
        int          blank_cyc;
        logic [71:0] exp_a;
        logic [71:0] exp_b;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [PW-1:0] duty_a;
    logic          blank;
    logic          busy;
    logic          tube_clk;
    logic          tube_data;
    logic          tube_sel;
    logic          tube_pwm;
    logic          tube_en;

    nixie_frame_tx_if fif ();

    nixie_frame_tx #(
        .CLK_DIV (CD),
        .PWM_W   (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_if  (fif),
        .duty_a    (duty_a),
        .blank     (blank),
        .busy      (busy),
        .tube_clk  (tube_clk),
        .tube_data (tube_data),
        .tube_sel  (tube_sel),
        .tube_pwm  (tube_pwm),
        .tube_en   (tube_en)
    );

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CPLD: two left-shift registers clocked by tube_clk rises.
    logic [71:0] cpld_a = '0;
    logic [71:0] cpld_b = '0;
    int          rises  = 0;
    always @(posedge tube_clk) begin
        if (tube_sel) cpld_a <= {cpld_a[70:0], tube_data};
        else          cpld_b <= {cpld_b[70:0], tube_data};
        rises <= rises + 1;
    end

    // Expected PWM counter value.
    int pwm_cnt = 0;
    always @(posedge clk) begin
        if (rst) pwm_cnt <= 0;
        else     pwm_cnt <= (pwm_cnt + 1) % PERIOD;
    end

    // Continuous checks of the override and of data/sel stability while tube_clk is high.
    int   ovr_err  = 0;
    int   hold_err = 0;
    logic prev_data = 1'b0;
    logic prev_sel  = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1 && tube_sel === 1'b1 && tube_pwm !== 1'b0) ovr_err++;
        if (busy === 1'b1 && tube_sel === 1'b0 && tube_clk === 1'b1 && tube_pwm !== 1'b1) ovr_err++;
        if (tube_clk === 1'b1 && (tube_data !== prev_data || tube_sel !== prev_sel)) hold_err++;
        prev_data = tube_data;
        prev_sel  = tube_sel;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int t;
        t = 0;
        while (fif.frame_ready !== 1'b1 && t < 4 * FRAME_CYC) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_ready_wait"}, fif.frame_ready, 1'b1);
    endtask

    task automatic send_frame(input string tag, input logic [71:0] fa, input logic [71:0] fb,
                              input int blank_cyc, input logic [71:0] exp_a, input logic [71:0] exp_b);
        int lat;
        int lat_rise;
        int base_r;
        int base_o;
        int base_h;
        fif.frame_a     = fa;
        fif.frame_b     = fb;
        fif.frame_valid = 1'b1;
        wait_ready(tag);
        base_r = rises;
        base_o = ovr_err;
        base_h = hold_err;
        @(negedge clk);
        fif.frame_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_ready_low"}, fif.frame_ready, 1'b0);
        lat      = 0;
        lat_rise = -1;
        while (fif.frame_ready !== 1'b1 && lat < 2 * FRAME_CYC) begin
            if (tube_clk === 1'b1 && lat_rise < 0) lat_rise = lat;
            if (lat == blank_cyc) begin
                chk({tag, "_en_before"}, tube_en, 1'b1);
                blank = 1'b1;
            end
            if (blank_cyc >= 0 && lat == blank_cyc + 1) chk({tag, "_en_blanked"}, tube_en, 1'b0);
            @(negedge clk);
            lat++;
        end
        blank = 1'b0;
        chk({tag, "_first_rise"}, lat_rise, CD);
        chk({tag, "_ready_lat"}, lat, FRAME_CYC + 1);
        chk({tag, "_rises"}, rises - base_r, 144);
        chk({tag, "_cpld_a"}, cpld_a, exp_a);
        chk({tag, "_cpld_b"}, cpld_b, exp_b);
        chk({tag, "_override"}, ovr_err - base_o, 0);
        chk({tag, "_hold"}, hold_err - base_h, 0);
        $display("frame %s: a=%h b=%h rise@%0d ready@%0d rises=%0d", tag, cpld_a, cpld_b,
                 lat_rise, lat, rises - base_r);
    endtask

    task automatic pwm_measure(input string tag, input logic [7:0] duty, input int exp_high);
        int highs;
        duty_a = duty;
        @(negedge clk);
        while (pwm_cnt != 0) @(negedge clk);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (tube_pwm === 1'b1) highs++;
            @(negedge clk);
        end
        chk(tag, highs, exp_high);
        $display("pwm %s: duty=%0d high=%0d/%0d", tag, duty, highs, PERIOD);
    endtask

    vec_t vecs[4];

    initial begin
        int highs;
        int lat;
        int base_r;
        vecs[0] = '{72'h80_0000_0000_0000_0001, {9{8'hA5}}, 8'd255, -1,
                    72'h80_0000_0000_0000_0001, {9{8'hA5}}};
        vecs[1] = '{72'h01_2345_6789_ABCD_EFFE, 72'hFF_0000_FFFF_0000_FF00, 8'd0, -1,
                    72'h01_2345_6789_ABCD_EFFE, 72'hFF_0000_FFFF_0000_FF00};
        vecs[2] = '{{72{1'b1}}, 72'h0, 8'd128, 30,
                    {72{1'b1}}, 72'h0};
        vecs[3] = '{72'h0, 72'h5A_C3_3C_96_69_0F_F0_81_18, 8'd255, 200,
                    72'h0, 72'h5A_C3_3C_96_69_0F_F0_81_18};

        rst             = 1'b1;
        duty_a          = '0;
        blank           = 1'b0;
        fif.frame_a     = '0;
        fif.frame_b     = '0;
        fif.frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tube_clk", tube_clk, 1'b0);
        chk("rst_tube_data", tube_data, 1'b0);
        chk("rst_tube_sel", tube_sel, 1'b0);
        chk("rst_tube_pwm", tube_pwm, 1'b0);
        chk("rst_tube_en", tube_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_ready", fif.frame_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", fif.frame_ready, 1'b1);
        chk("post_rst_en", tube_en, 1'b1);
        chk("post_rst_pwm", tube_pwm, 1'b0);

        pwm_measure("pwm_duty0", 8'd0, 0);
        pwm_measure("pwm_duty128", 8'd128, 128);
        pwm_measure("pwm_duty255", 8'd255, 255);
        pwm_measure("pwm_duty128b", 8'd128, 128);

        // duty 128 is live from count 0; switch to 64 at count 10 of this period.
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_cnt == 10) duty_a = 8'd64;
            if (tube_pwm === 1'b1) highs++;
            @(negedge clk);
        end
        chk("pwm_mid_change_same_period", highs, 128);
        $display("pwm mid_change period0: high=%0d", highs);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (tube_pwm === 1'b1) highs++;
            @(negedge clk);
        end
        chk("pwm_mid_change_next_period", highs, 64);
        $display("pwm mid_change period1: high=%0d", highs);

        for (int v = 0; v < 4; v++) begin
            duty_a = vecs[v].duty;
            send_frame($sformatf("vec%0d", v), vecs[v].fa, vecs[v].fb, vecs[v].blank_cyc,
                       vecs[v].exp_a, vecs[v].exp_b);
        end

        // frame_valid held high; inputs change mid-shift and must not disturb frame 1.
        duty_a          = 8'd128;
        fif.frame_a     = 72'hC0_FFEE_DDCC_BBAA_9988;
        fif.frame_b     = 72'h11_2233_4455_6677_8899;
        fif.frame_valid = 1'b1;
        wait_ready("hs1");
        base_r = rises;
        @(negedge clk);
        lat = 0;
        while (fif.frame_ready !== 1'b1 && lat < 2 * FRAME_CYC) begin
            if (lat == 50) begin
                fif.frame_a = 72'h3C_0F0F_F0F0_1234_5678;
                fif.frame_b = 72'hE7_8765_4321_ABAB_CDCD;
            end
            @(negedge clk);
            lat++;
        end
        chk("hs1_ready_lat", lat, FRAME_CYC + 1);
        chk("hs1_cpld_a", cpld_a, 72'hC0_FFEE_DDCC_BBAA_9988);
        chk("hs1_cpld_b", cpld_b, 72'h11_2233_4455_6677_8899);
        chk("hs1_rises", rises - base_r, 144);
        $display("frame hs1: a=%h b=%h ready@%0d", cpld_a, cpld_b, lat);
        @(negedge clk);
        chk("hs2_accepted", busy, 1'b1);
        fif.frame_valid = 1'b0;
        lat = 0;
        while (fif.frame_ready !== 1'b1 && lat < 2 * FRAME_CYC) begin
            @(negedge clk);
            lat++;
        end
        chk("hs2_ready_lat", lat, FRAME_CYC + 1);
        chk("hs2_cpld_a", cpld_a, 72'h3C_0F0F_F0F0_1234_5678);
        chk("hs2_cpld_b", cpld_b, 72'hE7_8765_4321_ABAB_CDCD);
        chk("hs2_rises", rises - base_r, 288);
        $display("frame hs2: a=%h b=%h ready@%0d", cpld_a, cpld_b, lat);

        // Reset 40 bits into bank B, then a full frame must overwrite the partial state.
        fif.frame_a     = 72'hAA_AAAA_AAAA_AAAA_AAAA;
        fif.frame_b     = 72'h55_5555_5555_5555_5555;
        fif.frame_valid = 1'b1;
        wait_ready("abort");
        base_r = rises;
        @(negedge clk);
        fif.frame_valid = 1'b0;
        lat = 0;
        while (rises - base_r < 72 + 40 && lat < 2 * FRAME_CYC) begin
            @(negedge clk);
            lat++;
        end
        chk("abort_reached_b40", rises - base_r, 112);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tube_clk", tube_clk, 1'b0);
        chk("abort_tube_data", tube_data, 1'b0);
        chk("abort_tube_sel", tube_sel, 1'b0);
        chk("abort_tube_pwm", tube_pwm, 1'b0);
        chk("abort_tube_en", tube_en, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_frame_ready", fif.frame_ready, 1'b0);
        $display("abort: reset after %0d rises", rises - base_r);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_back", fif.frame_ready, 1'b1);
        duty_a = 8'd0;
        send_frame("after_abort", 72'h96_1E2D_3C4B_5A69_7887, 72'h0F_EDCB_A987_6543_2101, -1,
                   72'h96_1E2D_3C4B_5A69_7887, 72'h0F_EDCB_A987_6543_2101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
